// File: rtl/queue_bank_if.sv
// queue_bank_if
// Bundles the packet-buffer data path between the switch/drain logic (master)
// and the queue bank itself (slave).
// Signals:
//   write       one-hot push strobe, write[q] pushes p_in into queue q
//   p_in        packet data accompanying write
//   read_tick   single-cycle drain request
//   out_valid   single-cycle pulse marking a popped packet
//   out_pkt     last popped packet (held until the next pop)
//   out_queue   queue index of the last pop
//   occ         packed per-queue occupancy, queue q at [q*CNT_W +: CNT_W]
//   drop_pulse  per-queue pulse when a push was discarded
//   drop_cnt    packed per-queue saturating drop counters
interface queue_bank_if #(
    parameter int PKT_W  = 4,
    parameter int CNT_W  = 3,
    parameter int DROP_W = 8
);
    logic [3:0]          write;
    logic [PKT_W-1:0]    p_in;
    logic                read_tick;
    logic                out_valid;
    logic [PKT_W-1:0]    out_pkt;
    logic [1:0]          out_queue;
    logic [4*CNT_W-1:0]  occ;
    logic [3:0]          drop_pulse;
    logic [4*DROP_W-1:0] drop_cnt;

    modport master (
        output write, p_in, read_tick,
        input  out_valid, out_pkt, out_queue, occ, drop_pulse, drop_cnt
    );

    modport slave (
        input  write, p_in, read_tick,
        output out_valid, out_pkt, out_queue, occ, drop_pulse, drop_cnt
    );
endinterface

// File: rtl/queue_bank.sv
// queue_bank
// Four circular packet FIFOs fed by a one-hot push strobe and drained one
// packet per read_tick by a round-robin arbiter. Full queues discard pushes
// and count the drops in saturating counters.
// Ports:
//   fract_clk  system clock, everything on the rising edge
//   rst_n      synchronous active-low reset
//   bus        queue_bank_if slave: push strobe/data, drain tick, popped
//              packet outputs, occupancy, drop pulses and drop counters
module queue_bank #(
    parameter int DEPTH  = 6,
    parameter int PKT_W  = 4,
    parameter int CNT_W  = 3,
    parameter int DROP_W = 8
) (
    input  logic          fract_clk,
    input  logic          rst_n,
    queue_bank_if.slave   bus
);

    logic [PKT_W-1:0]  mem        [4][DEPTH];
    logic [CNT_W-1:0]  wr_ptr     [4];
    logic [CNT_W-1:0]  rd_ptr     [4];
    logic [CNT_W-1:0]  occ_r      [4];
    logic [DROP_W-1:0] drop_cnt_r [4];
    logic [1:0]        last_served;

    logic              out_valid_r;
    logic [PKT_W-1:0]  out_pkt_r;
    logic [1:0]        out_queue_r;
    logic [3:0]        drop_pulse_r;

    logic              pop_any;
    logic [1:0]        pop_sel;
    logic [1:0]        scan_idx;
    logic [3:0]        pop_hit;
    logic [3:0]        push_ok;
    logic [3:0]        drop_now;

    logic [4*CNT_W-1:0]  occ_flat;
    logic [4*DROP_W-1:0] drop_flat;

    // Pointers wrap at DEPTH-1 explicitly since DEPTH need not be a power of two.
    function automatic logic [CNT_W-1:0] ptr_next(input logic [CNT_W-1:0] p);
        return (p == CNT_W'(DEPTH - 1)) ? '0 : p + CNT_W'(1);
    endfunction

    // Round-robin scan starting just after the last served queue. Occupancy
    // is taken before this cycle's pushes, so a push into an empty queue is
    // never popped in the same cycle.
    always_comb begin
        pop_any  = 1'b0;
        pop_sel  = '0;
        scan_idx = '0;
        for (int i = 1; i <= 4; i++) begin
            scan_idx = last_served + 2'(i);
            if (!pop_any && bus.read_tick && occ_r[scan_idx] != '0) begin
                pop_any = 1'b1;
                pop_sel = scan_idx;
            end
        end
    end

    // A full queue still accepts a push when it is popped in the same cycle.
    always_comb begin
        pop_hit  = '0;
        push_ok  = '0;
        drop_now = '0;
        for (int q = 0; q < 4; q++) begin
            pop_hit[q]  = pop_any && (pop_sel == 2'(q));
            push_ok[q]  = bus.write[q] && ((occ_r[q] != CNT_W'(DEPTH)) || pop_hit[q]);
            drop_now[q] = bus.write[q] && !push_ok[q];
        end
    end

    // Storage carries no reset; stale contents are unreachable once the
    // pointers and occupancy are cleared.
    always_ff @(posedge fract_clk) begin
        for (int q = 0; q < 4; q++) begin
            if (push_ok[q]) begin
                mem[q][wr_ptr[q]] <= bus.p_in;
            end
        end
    end

    always_ff @(posedge fract_clk) begin
        if (!rst_n) begin
            out_valid_r  <= 1'b0;
            out_pkt_r    <= '0;
            out_queue_r  <= '0;
            drop_pulse_r <= '0;
            last_served  <= 2'd3;
            for (int q = 0; q < 4; q++) begin
                wr_ptr[q]     <= '0;
                rd_ptr[q]     <= '0;
                occ_r[q]      <= '0;
                drop_cnt_r[q] <= '0;
            end
        end else begin
            out_valid_r  <= pop_any;
            drop_pulse_r <= drop_now;
            if (pop_any) begin
                out_pkt_r   <= mem[pop_sel][rd_ptr[pop_sel]];
                out_queue_r <= pop_sel;
                last_served <= pop_sel;
            end
            for (int q = 0; q < 4; q++) begin
                if (push_ok[q]) begin
                    wr_ptr[q] <= ptr_next(wr_ptr[q]);
                end
                if (pop_hit[q]) begin
                    rd_ptr[q] <= ptr_next(rd_ptr[q]);
                end
                case ({push_ok[q], pop_hit[q]})
                    2'b10:   occ_r[q] <= occ_r[q] + CNT_W'(1);
                    2'b01:   occ_r[q] <= occ_r[q] - CNT_W'(1);
                    default: occ_r[q] <= occ_r[q];
                endcase
                if (drop_now[q] && drop_cnt_r[q] != '1) begin
                    drop_cnt_r[q] <= drop_cnt_r[q] + DROP_W'(1);
                end
            end
        end
    end

    always_comb begin
        occ_flat  = '0;
        drop_flat = '0;
        for (int q = 0; q < 4; q++) begin
            occ_flat[q*CNT_W +: CNT_W]    = occ_r[q];
            drop_flat[q*DROP_W +: DROP_W] = drop_cnt_r[q];
        end
    end

    assign bus.out_valid  = out_valid_r;
    assign bus.out_pkt    = out_pkt_r;
    assign bus.out_queue  = out_queue_r;
    assign bus.drop_pulse = drop_pulse_r;
    assign bus.occ        = occ_flat;
    assign bus.drop_cnt   = drop_flat;

endmodule

// File: tb/tb_queue_bank.sv
// tb_queue_bank
// Self-checking bench for queue_bank. A behavioural model built from plain
// SystemVerilog queues predicts every pop; predicted packets go into a
// scoreboard that an independent monitor drains whenever out_valid is seen.
// Occupancy, drop pulses and drop counters are compared against the model
// after every cycle. Directed scenarios are followed by a randomized phase.
module tb_queue_bank;

    localparam int DEPTH  = 6;
    localparam int PKT_W  = 4;
    localparam int CNT_W  = 3;
    localparam int DROP_W = 8;

    typedef struct packed {
        logic [PKT_W-1:0] pkt;
        logic [1:0]       q;
    } exp_t;

    logic fract_clk = 1'b0;
    logic rst_n     = 1'b0;

    queue_bank_if #(.PKT_W(PKT_W), .CNT_W(CNT_W), .DROP_W(DROP_W)) bus ();

    queue_bank #(
        .DEPTH(DEPTH), .PKT_W(PKT_W), .CNT_W(CNT_W), .DROP_W(DROP_W)
    ) dut (
        .fract_clk (fract_clk),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 fract_clk = ~fract_clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [PKT_W-1:0] mq [4][$];
    int               dcount [4];
    int               last_srv;
    logic [3:0]       exp_drop;
    exp_t             sb [$];
    exp_t             mon_e;

    task automatic checkValue(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, advances the model, and waits for the
    // following falling edge so outputs of that cycle can be sampled.
    task automatic applyStimulus(input logic [3:0] w, input logic [PKT_W-1:0] p,
                                 input logic rt, input logic rs);
        int   sel;
        int   c;
        int   pre [4];
        exp_t e;
        bus.write     = w;
        bus.p_in      = p;
        bus.read_tick = rt;
        rst_n         = rs;
        if (!rs) begin
            for (int q = 0; q < 4; q++) begin
                mq[q].delete();
                dcount[q] = 0;
            end
            last_srv = 3;
            exp_drop = '0;
        end else begin
            sel = -1;
            for (int q = 0; q < 4; q++) pre[q] = mq[q].size();
            if (rt) begin
                for (int i = 1; i <= 4; i++) begin
                    c = (last_srv + i) % 4;
                    if (sel < 0 && pre[c] != 0) sel = c;
                end
            end
            if (sel >= 0) begin
                e.pkt = mq[sel].pop_front();
                e.q   = 2'(sel);
                sb.push_back(e);
                last_srv = sel;
            end
            exp_drop = '0;
            for (int q = 0; q < 4; q++) begin
                if (w[q]) begin
                    if (pre[q] == DEPTH && sel != q) begin
                        exp_drop[q] = 1'b1;
                        if (dcount[q] < 255) dcount[q]++;
                    end else begin
                        mq[q].push_back(p);
                    end
                end
            end
        end
        @(negedge fract_clk);
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ":pending_pops"}, sb.size(), 0);
        checkValue({tag, ":drop_pulse"}, int'(bus.drop_pulse), int'(exp_drop));
        for (int q = 0; q < 4; q++) begin
            checkValue($sformatf("%s:occ%0d", tag, q),
                       int'(bus.occ[q*CNT_W +: CNT_W]), mq[q].size());
            checkValue($sformatf("%s:drop_cnt%0d", tag, q),
                       int'(bus.drop_cnt[q*DROP_W +: DROP_W]), dcount[q]);
        end
    endtask

    // Monitor: consumes one scoreboard entry per observed out_valid pulse.
    always @(posedge fract_clk) begin
        #1;
        if (bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_out_valid actual=1 expected=0 out_queue=%0d", bus.out_queue);
            end else begin
                mon_e = sb.pop_front();
                checkValue("out_pkt", int'(bus.out_pkt), int'(mon_e.pkt));
                checkValue("out_queue", int'(bus.out_queue), int'(mon_e.q));
            end
        end
    end

    initial begin
        int drops_seen;
        int rr_seq [6];
        logic [3:0] w;
        logic rt;
        logic rs;

        rr_seq = '{0, 1, 3, 0, 1, 3};
        bus.write     = '0;
        bus.p_in      = '0;
        bus.read_tick = 1'b0;
        for (int q = 0; q < 4; q++) dcount[q] = 0;
        last_srv = 3;
        exp_drop = '0;
        @(negedge fract_clk);

        // T1: reset held with random activity
        repeat (2) applyStimulus(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
        checkOutput("t1");
        checkValue("t1:out_valid", int'(bus.out_valid), 0);
        checkValue("t1:out_pkt", int'(bus.out_pkt), 0);
        checkValue("t1:out_queue", int'(bus.out_queue), 0);
        checkValue("t1:occ_all", int'(bus.occ), 0);

        // T2: single packet through queue 2
        applyStimulus(4'b0100, 4'b1001, 1'b0, 1'b1);
        checkOutput("t2_push");
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1);
        checkOutput("t2_pop");
        checkValue("t2:out_valid", int'(bus.out_valid), 1);
        checkValue("t2:out_pkt", int'(bus.out_pkt), 9);
        checkValue("t2:out_queue", int'(bus.out_queue), 2);

        // T3: overflow queue 1 then drain it
        drops_seen = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b0010, 4'($urandom), 1'b0, 1'b1);
            checkOutput("t3_fill");
            if (bus.drop_pulse[1]) drops_seen++;
        end
        checkValue("t3:drop_pulses", drops_seen, 2);
        checkValue("t3:occ1", int'(bus.occ[CNT_W +: CNT_W]), 6);
        checkValue("t3:drop_cnt1", int'(bus.drop_cnt[DROP_W +: DROP_W]), 2);
        repeat (6) begin
            applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1);
            checkOutput("t3_drain");
        end

        // T4: round-robin over queues 0,1,3 from a fresh reset
        applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
        repeat (2) begin
            applyStimulus(4'b1011, 4'($urandom), 1'b0, 1'b1);
            checkOutput("t4_fill");
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1);
            checkOutput("t4_drain");
            checkValue($sformatf("t4:rr_valid%0d", i), int'(bus.out_valid), 1);
            checkValue($sformatf("t4:rr_queue%0d", i), int'(bus.out_queue), rr_seq[i]);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1);
        checkOutput("t4_empty");
        checkValue("t4:empty_valid", int'(bus.out_valid), 0);

        // T5: full queue 0 pushed and popped in the same cycle
        repeat (6) begin
            applyStimulus(4'b0001, 4'($urandom), 1'b0, 1'b1);
            checkOutput("t5_fill");
        end
        applyStimulus(4'b0001, 4'($urandom), 1'b1, 1'b1);
        checkOutput("t5_pushpop");
        checkValue("t5:occ0", int'(bus.occ[0 +: CNT_W]), 6);
        checkValue("t5:drop_pulse0", int'(bus.drop_pulse[0]), 0);
        checkValue("t5:out_valid", int'(bus.out_valid), 1);

        // T6: reset with three queues busy and drops already counted
        repeat (7) begin
            applyStimulus(4'b0111, 4'($urandom), 1'b0, 1'b1);
            checkOutput("t6_fill");
        end
        applyStimulus(4'b0111, 4'($urandom), 1'b1, 1'b0);
        checkOutput("t6_reset");
        checkValue("t6:out_valid_in_reset", int'(bus.out_valid), 0);
        checkValue("t6:occ_all", int'(bus.occ), 0);
        checkValue("t6:drop_cnt_all", int'(bus.drop_cnt), 0);
        applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1);
        checkOutput("t6_tick");
        checkValue("t6:out_valid", int'(bus.out_valid), 0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            w  = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom);
            rt = ($urandom_range(0, 2) != 0);
            rs = ($urandom_range(0, 99) != 0);
            applyStimulus(w, 4'($urandom), rt, rs);
            checkOutput("rand");
        end

        repeat (2) begin
            applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
            checkOutput("final");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
